// File: rtl/mfp_ahb_sword_shift_ctrl_if.sv
// Signal bundle between the GPIO output registers and the SWORD shift-out scheduler.
// The scheduler takes the slave side; whatever drives the data values takes the master side.
interface mfp_ahb_sword_shift_ctrl_if #(
    parameter int LED_W = 16,
    parameter int SEG_W = 64
);
    logic             EN;
    logic [LED_W-1:0] LED_DATA;
    logic [SEG_W-1:0] SEG_DATA;
    logic             SDAT;
    logic             LED_SCLK;
    logic             SEG_SCLK;
    logic             LED_LAT;
    logic             SEG_LAT;
    logic             BUSY;
    logic             DONE;

    modport master (
        output EN, LED_DATA, SEG_DATA,
        input  SDAT, LED_SCLK, SEG_SCLK, LED_LAT, SEG_LAT, BUSY, DONE
    );

    modport slave (
        input  EN, LED_DATA, SEG_DATA,
        output SDAT, LED_SCLK, SEG_SCLK, LED_LAT, SEG_LAT, BUSY, DONE
    );
endinterface

// File: rtl/mfp_ahb_sword_shift_ctrl.sv
// One serial shift engine shared round-robin between the LED and 7-segment 74HC595 chains.
// A chain is re-sent only when its input value differs from the value last loaded for it.
module mfp_ahb_sword_shift_ctrl #(
    parameter int LED_W   = 16,
    parameter int SEG_W   = 64,
    parameter int CLK_DIV = 2
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    mfp_ahb_sword_shift_ctrl_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (SEG_W > 1) ? $clog2(SEG_W) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, GAP} state_t;
    typedef enum logic {CH_LED, CH_SEG} chan_t;

    state_t           state, state_next;
    chan_t            grant, grant_next;
    chan_t            last_grant, last_grant_next;
    logic [SEG_W-1:0] sreg, sreg_next;
    logic [BIT_W-1:0] bitcnt, bitcnt_next;
    logic [DIV_W-1:0] divcnt, divcnt_next;
    logic [LED_W-1:0] shadow_led, shadow_led_next;
    logic [SEG_W-1:0] shadow_seg, shadow_seg_next;
    logic             pend_led, pend_led_next;
    logic             pend_seg, pend_seg_next;
    logic             led_changed, seg_changed;
    logic             div_end;

    assign div_end = (divcnt == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        sreg_next       = sreg;
        bitcnt_next     = bitcnt;
        divcnt_next     = divcnt;
        shadow_led_next = shadow_led;
        shadow_seg_next = shadow_seg;

        // The granted channel is being captured in LOAD, so its stale shadow must not re-arm it.
        led_changed = (bus.LED_DATA != shadow_led) && !(state == LOAD && grant == CH_LED);
        seg_changed = (bus.SEG_DATA != shadow_seg) && !(state == LOAD && grant == CH_SEG);
        pend_led_next = pend_led | led_changed;
        pend_seg_next = pend_seg | seg_changed;

        case (state)
            IDLE: begin
                if (bus.EN && (pend_led || pend_seg)) begin
                    if (pend_led && pend_seg)
                        grant_next = (last_grant == CH_SEG) ? CH_LED : CH_SEG;
                    else if (pend_led)
                        grant_next = CH_LED;
                    else
                        grant_next = CH_SEG;
                    if (grant_next == CH_LED)
                        pend_led_next = 1'b0;
                    else
                        pend_seg_next = 1'b0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // LED value is left-justified so both chains shift from the same MSB.
                if (grant == CH_LED) begin
                    shadow_led_next = bus.LED_DATA;
                    sreg_next       = SEG_W'(bus.LED_DATA) << (SEG_W - LED_W);
                    bitcnt_next     = BIT_W'(LED_W - 1);
                end else begin
                    shadow_seg_next = bus.SEG_DATA;
                    sreg_next       = bus.SEG_DATA;
                    bitcnt_next     = BIT_W'(SEG_W - 1);
                end
                divcnt_next = '0;
                state_next  = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_end) begin
                    divcnt_next = '0;
                    state_next  = SHIFT_HI;
                end else begin
                    divcnt_next = divcnt + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    divcnt_next = '0;
                    if (bitcnt == '0) begin
                        state_next = LATCH;
                    end else begin
                        sreg_next   = sreg << 1;
                        bitcnt_next = bitcnt - 1'b1;
                        state_next  = SHIFT_LO;
                    end
                end else begin
                    divcnt_next = divcnt + 1'b1;
                end
            end
            LATCH: begin
                if (div_end) begin
                    divcnt_next = '0;
                    state_next  = GAP;
                end else begin
                    divcnt_next = divcnt + 1'b1;
                end
            end
            GAP: begin
                last_grant_next = grant;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state        <= IDLE;
            grant        <= CH_LED;
            last_grant   <= CH_SEG;
            sreg         <= '0;
            bitcnt       <= '0;
            divcnt       <= '0;
            shadow_led   <= '0;
            shadow_seg   <= '0;
            pend_led     <= 1'b1;
            pend_seg     <= 1'b1;
            bus.SDAT     <= 1'b0;
            bus.LED_SCLK <= 1'b0;
            bus.SEG_SCLK <= 1'b0;
            bus.LED_LAT  <= 1'b0;
            bus.SEG_LAT  <= 1'b0;
            bus.BUSY     <= 1'b0;
            bus.DONE     <= 1'b0;
        end else begin
            state        <= state_next;
            grant        <= grant_next;
            last_grant   <= last_grant_next;
            sreg         <= sreg_next;
            bitcnt       <= bitcnt_next;
            divcnt       <= divcnt_next;
            shadow_led   <= shadow_led_next;
            shadow_seg   <= shadow_seg_next;
            pend_led     <= pend_led_next;
            pend_seg     <= pend_seg_next;
            bus.SDAT     <= (state_next == SHIFT_LO || state_next == SHIFT_HI) && sreg_next[SEG_W-1];
            bus.LED_SCLK <= (state_next == SHIFT_HI) && (grant_next == CH_LED);
            bus.SEG_SCLK <= (state_next == SHIFT_HI) && (grant_next == CH_SEG);
            bus.LED_LAT  <= (state_next == LATCH) && (grant_next == CH_LED);
            bus.SEG_LAT  <= (state_next == LATCH) && (grant_next == CH_SEG);
            bus.BUSY     <= (state_next != IDLE);
            bus.DONE     <= (state_next == GAP);
        end
    end
endmodule
